fft_stage_sched: RTL and testbench

- Sequencer for the iterative FFT datapath: serial-to-parallel loader, input mux, butterfly, feedback register and parallel-to-serial unloader.
- Accepts one loaded frame from the loader and walks it through STAGES butterfly passes.
- Each pass is held for CALC_CYCLES cycles, giving the butterfly a multicycle path.
- Drives mux select, twiddle rotation, feedback-register write and output-load strobes, and stalls the final pass until the unloader is ready.

---
 rtl/fft_stage_sched.sv | 116 +++++++++++
 tb/tb_fft_stage_sched.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_stage_sched.sv
// Stage sequencer for an iterative FFT datapath: accepts a loaded frame, walks it
// through STAGES butterfly passes of CALC_CYCLES cycles each, then hands it to the unloader.
module fft_stage_sched #(
  parameter int unsigned STAGES      = 3,
  parameter int unsigned CALC_CYCLES = 2,
  parameter int unsigned FCNT_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sp_valid,
  output logic              sp_ack,
  input  logic              ps_ready,
  input  logic              flush,
  output logic              mux_flag,
  output logic [2:0]        rotation,
  output logic              reg_we,
  output logic              demux_flag,
  output logic              busy,
  output logic              stall,
  output logic              frame_done,
  output logic [FCNT_W-1:0] frame_cnt
);

  localparam int unsigned S_W    = 3;
  localparam int unsigned C_W    = 4;
  localparam logic [S_W-1:0] S_LAST = S_W'(STAGES - 1);
  localparam logic [C_W-1:0] C_LAST = C_W'(CALC_CYCLES - 1);

  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_t;

  state_t            state_q;
  logic [S_W-1:0]    s_q;
  logic [C_W-1:0]    c_q;
  logic [FCNT_W-1:0] frame_cnt_q;
  logic              frame_done_q;

  logic in_calc_c;
  logic c_last_c;
  logic s_last_c;
  logic final_c;
  logic complete_c;

  // Pass/phase decode; completion needs the unloader ready and no abort pending
  always_comb begin
    in_calc_c  = (state_q == CALC);
    c_last_c   = (c_q == C_LAST);
    s_last_c   = (s_q == S_LAST);
    final_c    = in_calc_c & c_last_c & s_last_c;
    complete_c = final_c & ps_ready & ~flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      s_q          <= '0;
      c_q          <= '0;
      frame_cnt_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= complete_c;
      if (complete_c) begin
        frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
      end
      case (state_q)
        IDLE: begin
          if (sp_valid && !flush) begin
            state_q <= CALC;
            s_q     <= '0;
            c_q     <= '0;
          end
        end
        CALC: begin
          if (flush) begin
            state_q <= IDLE;
            s_q     <= '0;
            c_q     <= '0;
          end else if (c_last_c) begin
            if (!s_last_c) begin
              s_q <= s_q + S_W'(1);
              c_q <= '0;
            end else if (ps_ready) begin
              state_q <= IDLE;
              s_q     <= '0;
              c_q     <= '0;
            end
            // final pass with unloader not ready: hold s/c until it is
          end else begin
            c_q <= c_q + C_W'(1);
          end
        end
        default: begin
          state_q <= IDLE;
          s_q     <= '0;
          c_q     <= '0;
        end
      endcase
    end
  end

  // Datapath controls decode from registered state; stall and demux see ps_ready directly
  always_comb begin
    busy       = in_calc_c;
    rotation   = in_calc_c ? s_q : '0;
    mux_flag   = in_calc_c & (s_q != '0);
    sp_ack     = in_calc_c & (s_q == '0) & (c_q == '0);
    reg_we     = in_calc_c & c_last_c & ~s_last_c;
    demux_flag = complete_c;
    stall      = final_c & ~ps_ready;
    frame_done = frame_done_q;
    frame_cnt  = frame_cnt_q;
  end

endmodule

// File: tb/tb_fft_stage_sched.sv
// Bench for fft_stage_sched: three configurations driven in lockstep, each checked every
// cycle against a position-in-frame reference model, plus directed checks of the key timings.
module tb_fft_stage_sched;

  logic clk = 1'b0;
  logic rst_n;
  logic sp_valid, ps_ready, flush;

  always #5 clk = ~clk;

  // DUT 0: 3 stages x 2 cycles; DUT 1: same with 2-bit frame counter; DUT 2: 1 stage x 1 cycle
  logic       a_ack, a_mux, a_we, a_dmx, a_busy, a_stall, a_done;
  logic [2:0] a_rot;
  logic [7:0] a_cnt;
  logic       b_ack, b_mux, b_we, b_dmx, b_busy, b_stall, b_done;
  logic [2:0] b_rot;
  logic [1:0] b_cnt;
  logic       c_ack, c_mux, c_we, c_dmx, c_busy, c_stall, c_done;
  logic [2:0] c_rot;
  logic [7:0] c_cnt;

  fft_stage_sched #(.STAGES(3), .CALC_CYCLES(2), .FCNT_W(8)) u_a (
    .clk(clk), .rst_n(rst_n), .sp_valid(sp_valid), .sp_ack(a_ack), .ps_ready(ps_ready),
    .flush(flush), .mux_flag(a_mux), .rotation(a_rot), .reg_we(a_we), .demux_flag(a_dmx),
    .busy(a_busy), .stall(a_stall), .frame_done(a_done), .frame_cnt(a_cnt));

  fft_stage_sched #(.STAGES(3), .CALC_CYCLES(2), .FCNT_W(2)) u_b (
    .clk(clk), .rst_n(rst_n), .sp_valid(sp_valid), .sp_ack(b_ack), .ps_ready(ps_ready),
    .flush(flush), .mux_flag(b_mux), .rotation(b_rot), .reg_we(b_we), .demux_flag(b_dmx),
    .busy(b_busy), .stall(b_stall), .frame_done(b_done), .frame_cnt(b_cnt));

  fft_stage_sched #(.STAGES(1), .CALC_CYCLES(1), .FCNT_W(8)) u_c (
    .clk(clk), .rst_n(rst_n), .sp_valid(sp_valid), .sp_ack(c_ack), .ps_ready(ps_ready),
    .flush(flush), .mux_flag(c_mux), .rotation(c_rot), .reg_we(c_we), .demux_flag(c_dmx),
    .busy(c_busy), .stall(c_stall), .frame_done(c_done), .frame_cnt(c_cnt));

  // Packed view: [17:10] cnt, 9 done, 8 stall, 7 busy, 6 demux, 5 reg_we, [4:2] rot, 1 mux, 0 ack
  logic [17:0] obs [3];
  logic [17:0] smp [3];
  assign obs[0] = {a_cnt, a_done, a_stall, a_busy, a_dmx, a_we, a_rot, a_mux, a_ack};
  assign obs[1] = {6'd0, b_cnt, b_done, b_stall, b_busy, b_dmx, b_we, b_rot, b_mux, b_ack};
  assign obs[2] = {c_cnt, c_done, c_stall, c_busy, c_dmx, c_we, c_rot, c_mux, c_ack};

  int st_p [3] = '{3, 3, 1};
  int cc_p [3] = '{2, 2, 1};
  int cw_p [3] = '{8, 2, 8};

  // Model state: a frame is just "how many cycles into the schedule" (pos)
  bit busy_m [3];
  int pos_m  [3];
  int cnt_m  [3];
  bit done_m [3];

  int checks   = 0;
  int failures = 0;
  int cyc_n    = 0;

  function automatic logic [17:0] exp_vec(int k);
    logic [17:0] v;
    int s, c;
    bit fin;
    v   = '0;
    s   = pos_m[k] / cc_p[k];
    c   = pos_m[k] % cc_p[k];
    fin = busy_m[k] && (pos_m[k] == st_p[k] * cc_p[k] - 1);
    v[17:10] = 8'(cnt_m[k]);
    v[9]     = done_m[k];
    v[8]     = fin && !ps_ready;
    v[7]     = busy_m[k];
    v[6]     = fin && ps_ready && !flush;
    v[5]     = busy_m[k] && (c == cc_p[k] - 1) && (s < st_p[k] - 1);
    v[4:2]   = busy_m[k] ? 3'(s) : 3'd0;
    v[1]     = busy_m[k] && (s != 0);
    v[0]     = busy_m[k] && (pos_m[k] == 0);
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      busy_m[k] = 1'b0;
      pos_m[k]  = 0;
      cnt_m[k]  = 0;
      done_m[k] = 1'b0;
    end
  endtask

  task automatic model_update(int k, bit in_v, bit in_r, bit in_f);
    bit fin;
    fin       = busy_m[k] && (pos_m[k] == st_p[k] * cc_p[k] - 1);
    done_m[k] = fin && in_r && !in_f;
    if (busy_m[k]) begin
      if (in_f) begin
        busy_m[k] = 1'b0;
        pos_m[k]  = 0;
      end else if (fin) begin
        if (in_r) begin
          busy_m[k] = 1'b0;
          pos_m[k]  = 0;
          cnt_m[k]  = (cnt_m[k] + 1) % (1 << cw_p[k]);
        end
      end else begin
        pos_m[k] = pos_m[k] + 1;
      end
    end else if (in_v && !in_f) begin
      busy_m[k] = 1'b1;
      pos_m[k]  = 0;
    end
  endtask

  // One clock: compare all DUTs mid-cycle, then advance the model across the edge
  task automatic step();
    logic [17:0] e;
    bit v, r, f;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      e      = exp_vec(k);
      smp[k] = obs[k];
      checks++;
      assert (obs[k] === e) else begin
        failures++;
        $error("FAIL model_dut%0d cyc=%0d obs=%h exp=%h", k, cyc_n, obs[k], e);
      end
    end
    v = sp_valid; r = ps_ready; f = flush;
    @(posedge clk);
    for (int k = 0; k < 3; k++) model_update(k, v, r, f);
    cyc_n++;
    #1;
  endtask

  task automatic chk(string tag, int o, int e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s cyc=%0d obs=%0d exp=%0d", tag, cyc_n, o, e);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; sp_valid = 1'b0; ps_ready = 1'b1; flush = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  int rot_e [6] = '{0, 0, 1, 1, 2, 2};
  int mux_e [6] = '{0, 0, 1, 1, 1, 1};
  int wrap_e [5] = '{1, 2, 3, 0, 1};
  int cnt0;

  initial begin
    do_reset();
    step();
    chk("reset_zero", int'(smp[0]), 0);
    chk("reset_zero_c", int'(smp[2]), 0);

    // Nominal frame
    sp_valid = 1'b1; ps_ready = 1'b1;
    step();
    sp_valid = 1'b0;
    for (int cy = 1; cy <= 7; cy++) begin
      step();
      if (cy <= 6) begin
        chk("nom_rot", int'(smp[0][4:2]), rot_e[cy-1]);
        chk("nom_mux", int'(smp[0][1]), mux_e[cy-1]);
      end
      chk("nom_ack", int'(smp[0][0]), int'(cy == 1));
      chk("nom_we", int'(smp[0][5]), int'(cy == 2 || cy == 4));
      chk("nom_demux", int'(smp[0][6]), int'(cy == 6));
      chk("nom_done", int'(smp[0][9]), int'(cy == 7));
      if (cy == 1) begin
        chk("edge_demux", int'(smp[2][6]), 1);
        chk("edge_mux", int'(smp[2][1]), 0);
      end
    end
    chk("nom_cnt", int'(smp[0][17:10]), 1);

    // Backpressure on the final pass
    sp_valid = 1'b1;
    step();
    sp_valid = 1'b0;
    for (int cy = 1; cy <= 11; cy++) begin
      ps_ready = !(cy >= 6 && cy <= 9);
      step();
      chk("bp_stall", int'(smp[0][8]), int'(cy >= 6 && cy <= 9));
      if (cy >= 6 && cy <= 9) chk("bp_rot", int'(smp[0][4:2]), 2);
      chk("bp_demux", int'(smp[0][6]), int'(cy == 10));
      chk("bp_done", int'(smp[0][9]), int'(cy == 11));
    end
    ps_ready = 1'b1;

    // Flush during stage 1
    cnt0 = int'(smp[0][17:10]);
    sp_valid = 1'b1;
    step();
    sp_valid = 1'b0;
    for (int cy = 1; cy <= 8; cy++) begin
      flush = (cy == 3);
      step();
      if (cy == 4) chk("fl_busy", int'(smp[0][7]), 0);
      chk("fl_demux", int'(smp[0][6]), 0);
    end
    flush = 1'b0;
    chk("fl_cnt", int'(smp[0][17:10]), cnt0);

    // Flush coinciding with completion
    sp_valid = 1'b1;
    step();
    sp_valid = 1'b0;
    for (int cy = 1; cy <= 7; cy++) begin
      flush = (cy == 6);
      step();
      chk("flc_demux", int'(smp[0][6]), 0);
      if (cy == 7) chk("flc_done", int'(smp[0][9]), 0);
    end
    flush = 1'b0;
    chk("flc_cnt", int'(smp[0][17:10]), cnt0);

    // Back-to-back frames and counter wrap on the 2-bit instance
    do_reset();
    sp_valid = 1'b1; ps_ready = 1'b1;
    step();
    for (int cy = 1; cy <= 35; cy++) begin
      step();
      if (cy % 7 == 0) begin
        chk("wrap_done", int'(smp[1][9]), 1);
        chk("wrap_cnt", int'(smp[1][11:10]), wrap_e[cy/7 - 1]);
      end
    end
    sp_valid = 1'b0;

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      sp_valid = ($urandom_range(0, 1) == 1);
      ps_ready = ($urandom_range(0, 9) < 7);
      flush    = ($urandom_range(0, 19) == 0);
      step();
    end
    sp_valid = 1'b0; ps_ready = 1'b1; flush = 1'b0;
    repeat (10) step();

    // Reset in the middle of a frame
    sp_valid = 1'b1;
    step();
    sp_valid = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_zero", int'(obs[0]), 0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
